// File: rtl/alu_seq_pkg.sv
// Shared state encoding, instruction field layout and sign-extension helpers
// for the ALU instruction sequencer.
package alu_seq_pkg;

  localparam int unsigned INSN_W  = 16;
  localparam int unsigned CLS_W   = 3;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FIELD_W = 5;
  localparam int unsigned EXT_W   = 16;
  // Helpers return this width; callers narrow to their own DATA_W.
  localparam int unsigned SEXT_W  = 64;

  localparam int unsigned CLS_LSB = 13;
  localparam int unsigned OP_LSB  = 10;
  localparam int unsigned RD_LSB  = 5;
  localparam int unsigned SRC_LSB = 0;

  localparam logic [CLS_W-1:0] CLS_IMM5 = 3'b000;
  localparam logic [CLS_W-1:0] CLS_REG  = 3'b001;
  localparam logic [CLS_W-1:0] CLS_EXT  = 3'b010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_A,
    S_PC1,
    S_FETCH,
    S_LD_B,
    S_EXEC,
    S_WB,
    S_DONE,
    S_ILL
  } state_t;

  function automatic logic [SEXT_W-1:0] sext5(input logic [FIELD_W-1:0] v);
    return {{(SEXT_W-FIELD_W){v[FIELD_W-1]}}, v};
  endfunction

  function automatic logic [SEXT_W-1:0] sext16(input logic [EXT_W-1:0] v);
    return {{(SEXT_W-EXT_W){v[EXT_W-1]}}, v};
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decode: class, legality and operand fields.
// Class 010 is legal only when ALU_SEQ_EXT_IMM_EN is defined.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [INSN_W-1:0]  instruction,
  output logic [CLS_W-1:0]   cls,
  output logic               legal,
  output logic [FIELD_W-1:0] rd,
  output logic [FIELD_W-1:0] src,
  output logic [OP_W-1:0]    alu_op
);

  assign cls    = instruction[CLS_LSB +: CLS_W];
  assign alu_op = instruction[OP_LSB  +: OP_W];
  assign rd     = instruction[RD_LSB  +: FIELD_W];
  assign src    = instruction[SRC_LSB +: FIELD_W];

  always_comb begin
    legal = (cls == CLS_IMM5) || (cls == CLS_REG);
`ifdef ALU_SEQ_EXT_IMM_EN
    if (cls == CLS_EXT) begin
      legal = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/alu_seq_fsm.sv
// ALU instruction sequencer: Moore strobe sequence for reg-reg, reg-imm5 and
// (with ALU_SEQ_EXT_IMM_EN) two-word extended-immediate instructions.
module alu_seq_fsm
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       instruction,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [REG_AW-1:0] rx_out,
  output logic [REG_AW-1:0] rx_in,
  output logic              alu_in0,
  output logic              alu_in1,
  output logic [2:0]        alu_op,
  output logic              alu_out_latch,
  output logic              alu_out_en,
  output logic              imm_out_en,
  output logic [DATA_W-1:0] param_out,
  output logic              pc_inc
);

  state_t             state;
  logic [CLS_W-1:0]   cls_q;
  logic [FIELD_W-1:0] rd_q;
  logic [FIELD_W-1:0] src_q;
  logic [OP_W-1:0]    op_q;

  logic [CLS_W-1:0]   dec_cls;
  logic               dec_legal;
  logic [FIELD_W-1:0] dec_rd;
  logic [FIELD_W-1:0] dec_src;
  logic [OP_W-1:0]    dec_op;

  alu_seq_decode u_decode (
    .instruction (instruction),
    .cls         (dec_cls),
    .legal       (dec_legal),
    .rd          (dec_rd),
    .src         (dec_src),
    .alu_op      (dec_op)
  );

  // Each branch picks the next state and loads the strobes that state shows,
  // so every output is a register decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cls_q         <= '0;
      rd_q          <= '0;
      src_q         <= '0;
      op_q          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      rx_out        <= '0;
      rx_in         <= '0;
      alu_in0       <= 1'b0;
      alu_in1       <= 1'b0;
      alu_op        <= '0;
      alu_out_latch <= 1'b0;
      alu_out_en    <= 1'b0;
      imm_out_en    <= 1'b0;
      param_out     <= '0;
      pc_inc        <= 1'b0;
    end else begin
      busy          <= 1'b1;
      done          <= 1'b0;
      illegal       <= 1'b0;
      rx_out        <= '0;
      rx_in         <= '0;
      alu_in0       <= 1'b0;
      alu_in1       <= 1'b0;
      alu_op        <= '0;
      alu_out_latch <= 1'b0;
      alu_out_en    <= 1'b0;
      imm_out_en    <= 1'b0;
      param_out     <= '0;
      pc_inc        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            cls_q <= dec_cls;
            rd_q  <= dec_rd;
            src_q <= dec_src;
            op_q  <= dec_op;
            if (dec_legal) begin
              state   <= S_LD_A;
              rx_out  <= REG_AW'(dec_rd);
              alu_in0 <= 1'b1;
              alu_op  <= dec_op;
            end else begin
              state   <= S_ILL;
              done    <= 1'b1;
              illegal <= 1'b1;
              pc_inc  <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        S_LD_A: begin
          alu_op <= op_q;
`ifdef ALU_SEQ_EXT_IMM_EN
          if (cls_q == CLS_EXT) begin
            state  <= S_PC1;
            pc_inc <= 1'b1;
          end else
`endif
          begin
            state   <= S_LD_B;
            alu_in1 <= 1'b1;
            if (cls_q == CLS_REG) begin
              rx_out <= REG_AW'(src_q);
            end else begin
              imm_out_en <= 1'b1;
              param_out  <= DATA_W'(sext5(src_q));
            end
          end
        end

`ifdef ALU_SEQ_EXT_IMM_EN
        S_PC1: begin
          state  <= S_FETCH;
          alu_op <= op_q;
        end

        // The second instruction word is taken on the exit edge of FETCH.
        S_FETCH: begin
          state      <= S_LD_B;
          alu_op     <= op_q;
          alu_in1    <= 1'b1;
          imm_out_en <= 1'b1;
          param_out  <= DATA_W'(sext16(instruction));
        end
`endif

        S_LD_B: begin
          state         <= S_EXEC;
          alu_op        <= op_q;
          alu_out_latch <= 1'b1;
        end

        S_EXEC: begin
          state      <= S_WB;
          alu_op     <= op_q;
          alu_out_en <= 1'b1;
          rx_in      <= REG_AW'(rd_q);
        end

        S_WB: begin
          state  <= S_DONE;
          done   <= 1'b1;
          pc_inc <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        S_ILL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Directed scoreboard bench for alu_seq_fsm: expected per-cycle output snapshots
// are queued when an instruction is issued and compared each cycle.
module tb_alu_seq_fsm;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
`ifdef ALU_SEQ_EXT_IMM_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          illegal;
    logic [AW-1:0] rx_out;
    logic [AW-1:0] rx_in;
    logic          alu_in0;
    logic          alu_in1;
    logic [2:0]    alu_op;
    logic          alu_out_latch;
    logic          alu_out_en;
    logic          imm_out_en;
    logic          pc_inc;
    logic [DW-1:0] param_out;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   instruction;
  logic          busy, done, illegal;
  logic [AW-1:0] rx_out, rx_in;
  logic          alu_in0, alu_in1;
  logic [2:0]    alu_op;
  logic          alu_out_latch, alu_out_en, imm_out_en, pc_inc;
  logic [DW-1:0] param_out;

  snap_t exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;

  alu_seq_fsm #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .instruction   (instruction),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .rx_out        (rx_out),
    .rx_in         (rx_in),
    .alu_in0       (alu_in0),
    .alu_in1       (alu_in1),
    .alu_op        (alu_op),
    .alu_out_latch (alu_out_latch),
    .alu_out_en    (alu_out_en),
    .imm_out_en    (imm_out_en),
    .param_out     (param_out),
    .pc_inc        (pc_inc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Compare current outputs with the next queued snapshot (idle if queue empty).
  task automatic check_now(input string tag);
    snap_t obs;
    snap_t exp;
    obs = {busy, done, illegal, rx_out, rx_in, alu_in0, alu_in1, alu_op,
           alu_out_latch, alu_out_en, imm_out_en, pc_inc, param_out};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : snap_t'(0);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  // Expected cycle-by-cycle outputs for one instruction, ending with the IDLE cycle.
  task automatic push_model(input logic [15:0] insn, input logic [15:0] fetch);
    logic [2:0] cls;
    logic [2:0] op;
    logic [4:0] rd;
    logic [4:0] src;
    snap_t s;
    cls = insn[15:13];
    op  = insn[12:10];
    rd  = insn[9:5];
    src = insn[4:0];
    if (!(cls == 3'b000 || cls == 3'b001 || (EXT && cls == 3'b010))) begin
      s = '0; s.busy = 1; s.done = 1; s.illegal = 1; s.pc_inc = 1;
      exp_q.push_back(s);
      exp_q.push_back(snap_t'(0));
      return;
    end
    s = '0; s.busy = 1; s.rx_out = rd; s.alu_in0 = 1; s.alu_op = op;
    exp_q.push_back(s);
    if (cls == 3'b010) begin
      s = '0; s.busy = 1; s.pc_inc = 1; s.alu_op = op;
      exp_q.push_back(s);
      s = '0; s.busy = 1; s.alu_op = op;
      exp_q.push_back(s);
    end
    s = '0; s.busy = 1; s.alu_in1 = 1; s.alu_op = op;
    if (cls == 3'b001) begin
      s.rx_out = rd == rd ? src : src;
    end else begin
      s.imm_out_en = 1;
      s.param_out  = (cls == 3'b010) ? DW'($signed(fetch)) : DW'($signed(src));
    end
    exp_q.push_back(s);
    s = '0; s.busy = 1; s.alu_op = op; s.alu_out_latch = 1;
    exp_q.push_back(s);
    s = '0; s.busy = 1; s.alu_op = op; s.alu_out_en = 1; s.rx_in = rd;
    exp_q.push_back(s);
    s = '0; s.busy = 1; s.done = 1; s.pc_inc = 1;
    exp_q.push_back(s);
    exp_q.push_back(snap_t'(0));
  endtask

  // Issue one instruction with a single start pulse and check every cycle.
  task automatic run_insn(input string tag, input logic [15:0] insn, input logic [15:0] fetch);
    int n;
    push_model(insn, fetch);
    n = exp_q.size();
    instruction = insn;
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s c%0d", tag, i));
      if (i == 1) start = 1'b0;
      if (EXT && insn[15:13] == 3'b010) begin
        if (i == 2) instruction = fetch;
        else if (i == 4) instruction = 16'($urandom);
      end else if (i == 1) begin
        instruction = 16'($urandom);
      end
    end
  endtask

  initial begin
    logic [15:0] held [3];
    int n;
    held[0] = 16'h2446;
    held[1] = 16'h003C;
    held[2] = 16'h1C1F;

    rst = 1'b1;
    start = 1'b0;
    instruction = 16'h0000;
    check("reset0");
    start = 1'b1;
    check("reset1");
    start = 1'b0;
    #2 rst = 1'b0;
    check("idle");

    run_insn("regreg",   16'h2446, 16'h0000);
    run_insn("imm5neg",  16'h003C, 16'h0000);
    run_insn("rd0",      16'h1C1F, 16'h0000);
    run_insn("rdeqrs",   16'h2863, 16'h0000);
    run_insn("imm5pos",  16'h0FEF, 16'h0000);
    run_insn("ext",      16'h4020, 16'h8001);
    run_insn("ext2",     16'h5CA3, 16'h7FFE);
    run_insn("ill7",     16'hE3A5, 16'h0000);
    run_insn("ill3",     16'h6000, 16'h0000);

    // Reset asserted asynchronously while in EXEC.
    push_model(16'h2446, 16'h0000);
    instruction = 16'h2446;
    start = 1'b1;
    check("rstx c1");
    start = 1'b0;
    check("rstx c2");
    check("rstx c3");
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check_now("rstx async");
    @(posedge clk);
    #2 rst = 1'b0;
    check("rstx post0");
    check("rstx post1");
    check("rstx post2");
    run_insn("after_rst", 16'h2446, 16'h0000);

    // start pulses while busy must be ignored.
    push_model(16'h0FEF, 16'h0000);
    n = exp_q.size();
    instruction = 16'h0FEF;
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("busy_start c%0d", i));
      start = logic'(i == 2 || i == 4);
      instruction = 16'($urandom);
    end
    check("busy_start tail");

    // start held high: one instruction accepted every 6 cycles.
    for (int k = 0; k < 3; k++) push_model(held[k], 16'h0000);
    n = exp_q.size();
    instruction = held[0];
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("held c%0d", i));
      if (i == n) start = 1'b0;
      if (i % 6 == 0 && i / 6 < 3) instruction = held[i / 6];
      else if (i % 6 == 1) instruction = 16'($urandom);
    end
    check("held tail0");
    check("held tail1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
